// File: rtl/mc_mul_if.sv
// Request/response bundle for the multicycle multiplier: operands and GO in,
// BUSY/W_RESULT handshake and the HI/LO result register out.
interface mc_mul_if #(
  parameter int W = 32
);
  logic           GO;
  logic           SIGNED;
  logic           ACC;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] ACC_IN;
  logic           BUSY;
  logic           W_RESULT;
  logic [W-1:0]   HI;
  logic [W-1:0]   LO;

  modport master (
    output GO, SIGNED, ACC, A, B, ACC_IN,
    input  BUSY, W_RESULT, HI, LO
  );

  modport slave (
    input  GO, SIGNED, ACC, A, B, ACC_IN,
    output BUSY, W_RESULT, HI, LO
  );
endinterface

// File: rtl/mc_mul.sv
// Radix-2 shift-and-add multiplier: W iterations plus one sign/accumulate fix-up
// cycle, with the GO/BUSY/W_RESULT handshake shared with the iterative divider.
module mc_mul #(
  parameter int W = 32
) (
  input  logic     CLK,
  input  logic     RESET,
  mc_mul_if.slave  bus
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   mcand_reg, mcand_next;
  logic [2*W-1:0] p_reg, p_next;
  logic           neg_reg, neg_next;
  logic           acc_reg, acc_next;
  logic [2*W-1:0] acc_in_reg, acc_in_next;
  logic [W-1:0]   hi_reg, hi_next;
  logic [W-1:0]   lo_reg, lo_next;
  logic           w_result_reg, w_result_next;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W-1:0]   addend;
  logic [W:0]     sum;
  logic [2*W-1:0] signed_p;
  logic [2*W-1:0] result;

  // Magnitudes are W-bit unsigned, so the most negative value maps to 2^(W-1)
  // without overflow; unsigned operands pass through untouched.
  assign mag_a = (bus.SIGNED && bus.A[W-1]) ? (-bus.A) : bus.A;
  assign mag_b = (bus.SIGNED && bus.B[W-1]) ? (-bus.B) : bus.B;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_addend
      assign addend[gi] = p_reg[0] & mcand_reg[gi];
    end
  endgenerate

  assign sum      = {1'b0, p_reg[2*W-1:W]} + {1'b0, addend};
  assign signed_p = neg_reg ? (-p_reg) : p_reg;
  assign result   = signed_p + (acc_reg ? acc_in_reg : {(2*W){1'b0}});

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mcand_next    = mcand_reg;
    p_next        = p_reg;
    neg_next      = neg_reg;
    acc_next      = acc_reg;
    acc_in_next   = acc_in_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    w_result_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.GO) begin
          mcand_next  = mag_a;
          p_next      = {{W{1'b0}}, mag_b};
          neg_next    = bus.SIGNED & (bus.A[W-1] ^ bus.B[W-1]);
          acc_next    = bus.ACC;
          acc_in_next = bus.ACC_IN;
          cnt_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        // Partial product shifts right; the carry out of the add enters at the top.
        p_next   = {sum, p_reg[W-1:1]};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(W - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        {hi_next, lo_next} = result;
        w_result_next      = 1'b1;
        state_next         = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mcand_reg    <= '0;
      p_reg        <= '0;
      neg_reg      <= 1'b0;
      acc_reg      <= 1'b0;
      acc_in_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      w_result_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mcand_reg    <= mcand_next;
      p_reg        <= p_next;
      neg_reg      <= neg_next;
      acc_reg      <= acc_next;
      acc_in_reg   <= acc_in_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      w_result_reg <= w_result_next;
    end
  end

  assign bus.BUSY     = (state_reg == RUN) || (state_reg == FIX);
  assign bus.W_RESULT = w_result_reg;
  assign bus.HI       = hi_reg;
  assign bus.LO       = lo_reg;

endmodule

// File: tb/tb_mc_mul.sv
// Bench for mc_mul (W=32): scenario tasks push expected products to a scoreboard;
// a negedge monitor pops them on W_RESULT and checks HI/LO hold in between.
module tb_mc_mul;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  mc_mul_if #(.W(W)) bus ();

  mc_mul #(.W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] held = '0;
  logic mon_en = 1'b0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn, input logic acc,
                                           input logic [2*W-1:0] ai);
    logic [2*W-1:0] ea, eb, p;
    ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    if (acc) p = p + ai;
    return p;
  endfunction

  always @(negedge CLK) begin
    if (mon_en) begin
      logic [2*W-1:0] exp_v;
      total++;
      if (bus.W_RESULT === 1'b1) begin
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_w_result: got pulse with HI=%h LO=%h, required no pulse", bus.HI, bus.LO);
        end else begin
          exp_v = sb_q.pop_front();
          if ({bus.HI, bus.LO} !== exp_v) begin
            bad++;
            $display("FAIL result: got %h_%h, required %h", bus.HI, bus.LO, exp_v);
          end
          held = exp_v;
        end
      end else if ({bus.HI, bus.LO} !== held) begin
        bad++;
        $display("FAIL hold: HI/LO changed without W_RESULT, got %h_%h, required %h", bus.HI, bus.LO, held);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_go(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic acc, input logic [2*W-1:0] ai);
    bus.A = a; bus.B = b; bus.SIGNED = sgn; bus.ACC = acc; bus.ACC_IN = ai;
    bus.GO = 1'b1;
    sb_q.push_back(model(a, b, sgn, acc, ai));
    step();
    bus.GO = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.SIGNED = 1'($urandom); bus.ACC = 1'($urandom);
    bus.ACC_IN = {$urandom, $urandom};
  endtask

  task automatic wait_result(input int start, output int n);
    n = start;
    while (bus.W_RESULT !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (bus.BUSY !== 1'b0 || bus.W_RESULT !== 1'b0) begin
      bad++; $display("FAIL reset_flags: BUSY=%b W_RESULT=%b, required 0 0", bus.BUSY, bus.W_RESULT);
    end
    total++;
    if (bus.HI !== '0 || bus.LO !== '0) begin
      bad++; $display("FAIL reset_hilo: got %h_%h, required 0_0", bus.HI, bus.LO);
    end
    RESET = 1'b0;
    held = '0;
    mon_en = 1'b1;
    step();
    $display("reset: BUSY=%b HI=%h LO=%h", bus.BUSY, bus.HI, bus.LO);
  endtask

  task automatic test_unsigned_max();
    int busy_bad = 0;
    drive_go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 33; c++) begin
      if (bus.BUSY !== 1'b1 || bus.W_RESULT !== 1'b0) busy_bad++;
      step();
    end
    total++;
    if (busy_bad != 0) begin
      bad++; $display("FAIL busy_window: %0d bad cycles in 1..33, required 0", busy_bad);
    end
    total++;
    if (bus.W_RESULT !== 1'b1 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL latency_34: W_RESULT=%b BUSY=%b at cycle 34, required 1 0", bus.W_RESULT, bus.BUSY);
    end
    total++;
    if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin
      bad++; $display("FAIL umax: got %h_%h, required fffffffe_00000001", bus.HI, bus.LO);
    end
    $display("umax: HI=%h LO=%h", bus.HI, bus.LO);
    step();
    total++;
    if (bus.W_RESULT !== 1'b0) begin
      bad++; $display("FAIL pulse_width: W_RESULT=%b at cycle 35, required 0", bus.W_RESULT);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] av[3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] bv[3] = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000};
    logic [2*W-1:0] ev[3] = '{64'hFFFFFFFF_FFFFFFF1, 64'h00000000_00000001, 64'h40000000_00000000};
    int n;
    for (int i = 0; i < 3; i++) begin
      drive_go(av[i], bv[i], 1'b1, 1'b0, '0);
      wait_result(1, n);
      total++;
      if (n != 34 || {bus.HI, bus.LO} !== ev[i]) begin
        bad++; $display("FAIL signed_%0d: got %h_%h after %0d cycles, required %h after 34", i, bus.HI, bus.LO, n, ev[i]);
      end
      $display("signed %h*%h: HI=%h LO=%h", av[i], bv[i], bus.HI, bus.LO);
    end
  endtask

  task automatic test_acc();
    int n;
    drive_go(32'd2, 32'd3, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    wait_result(1, n);
    total++;
    if (n != 34 || bus.HI !== 32'h0 || bus.LO !== 32'h5) begin
      bad++; $display("FAIL acc_wrap: got %h_%h after %0d cycles, required 0_5 after 34", bus.HI, bus.LO, n);
    end
    $display("acc wrap: HI=%h LO=%h", bus.HI, bus.LO);
    drive_go(32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h01234567_89ABCDEF);
    wait_result(1, n);
    total++;
    if (n != 34 || {bus.HI, bus.LO} !== 64'h01234567_89ABCDEF) begin
      bad++; $display("FAIL zero_operand: got %h_%h after %0d cycles, required 0123456789abcdef after 34", bus.HI, bus.LO, n);
    end
    $display("zero operand: HI=%h LO=%h cycles=%0d", bus.HI, bus.LO, n);
  endtask

  task automatic test_go_while_busy();
    int n;
    logic [2*W-1:0] e;
    e = model(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, '0);
    drive_go(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, '0);
    repeat (9) step();
    bus.GO = 1'b1; bus.A = 32'd1; bus.B = 32'd1; bus.SIGNED = 1'b0; bus.ACC = 1'b1; bus.ACC_IN = 64'd5;
    step();
    bus.GO = 1'b0;
    wait_result(11, n);
    total++;
    if (n != 34 || {bus.HI, bus.LO} !== e) begin
      bad++; $display("FAIL go_while_busy: got %h_%h after %0d cycles, required %h after 34", bus.HI, bus.LO, n, e);
    end
    $display("go while busy: HI=%h LO=%h cycles=%0d", bus.HI, bus.LO, n);
    step();
    total++;
    if (bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL no_restart: BUSY=%b after result, required 0", bus.BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [2*W-1:0] e1, e2;
    e1 = model(32'd123456789, 32'd987654321, 1'b0, 1'b0, '0);
    e2 = model(32'hFFFE7960, 32'd77777, 1'b1, 1'b1, 64'h00000000_FFFF0000);
    drive_go(32'd123456789, 32'd987654321, 1'b0, 1'b0, '0);
    wait_result(1, n1);
    drive_go(32'hFFFE7960, 32'd77777, 1'b1, 1'b1, 64'h00000000_FFFF0000);
    total++;
    if (bus.BUSY !== 1'b1 || {bus.HI, bus.LO} !== e1) begin
      bad++; $display("FAIL b2b_start: BUSY=%b HI/LO=%h_%h, required 1 and %h", bus.BUSY, bus.HI, bus.LO, e1);
    end
    wait_result(1, n2);
    total++;
    if (n1 != 34 || n2 != 34 || {bus.HI, bus.LO} !== e2) begin
      bad++; $display("FAIL b2b_second: got %h_%h cycles %0d/%0d, required %h cycles 34/34", bus.HI, bus.LO, n1, n2, e2);
    end
    $display("back to back: HI=%h LO=%h cycles=%0d/%0d", bus.HI, bus.LO, n1, n2);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int n;
    drive_go(32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, '0);
    repeat (14) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    sb_q.delete();
    held = '0;
    total++;
    if (bus.BUSY !== 1'b0 || bus.W_RESULT !== 1'b0 || bus.HI !== '0 || bus.LO !== '0) begin
      bad++; $display("FAIL reset_mid: BUSY=%b W_RESULT=%b HI=%h LO=%h, required 0 0 0 0", bus.BUSY, bus.W_RESULT, bus.HI, bus.LO);
    end
    for (int c = 0; c < 40; c++) begin
      if (bus.W_RESULT === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL reset_no_pulse: %0d pulses, required 0", pulses);
    end
    bus.GO = 1'b1; bus.A = 32'd9; bus.B = 32'd9; bus.SIGNED = 1'b0; bus.ACC = 1'b0;
    RESET = 1'b1;
    step();
    bus.GO = 1'b0;
    RESET = 1'b0;
    total++;
    if (bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_over_go: BUSY=%b, required 0", bus.BUSY);
    end
    drive_go(32'd7, 32'd6, 1'b0, 1'b0, '0);
    wait_result(1, n);
    total++;
    if (n != 34 || bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
      bad++; $display("FAIL after_reset: got %h_%h after %0d cycles, required 0_2a after 34", bus.HI, bus.LO, n);
    end
    $display("after reset 7*6: HI=%h LO=%h", bus.HI, bus.LO);
  endtask

  task automatic test_random();
    int n;
    int lat_bad = 0;
    logic [W-1:0] a, b;
    for (int i = 0; i < 1200; i++) begin
      repeat ($urandom_range(0, 3)) step();
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = '0;
        1: b = '0;
        2: a = 32'h80000000;
        default: ;
      endcase
      drive_go(a, b, 1'($urandom), 1'($urandom), {$urandom, $urandom});
      wait_result(1, n);
      if (n != 34) lat_bad++;
    end
    total++;
    if (lat_bad != 0) begin
      bad++; $display("FAIL random_latency: %0d ops not at 34 cycles, required 0", lat_bad);
    end
    $display("random: 1200 ops, latency errors=%0d", lat_bad);
  endtask

  initial begin
    bus.GO = 1'b0; bus.SIGNED = 1'b0; bus.ACC = 1'b0;
    bus.A = '0; bus.B = '0; bus.ACC_IN = '0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_acc();
    test_go_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    step();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
